sprite_pixel_gen: RTL and testbench

//  Pixel source feeding the VGA timing controller's iRed/iGreen/iBlue. Consumes its pixel_x/pixel_y/oRequest,

---
 rtl/sprite_pkg.sv | 38 +++
 rtl/sprite_hit.sv | 46 ++++
 rtl/sprite_pixel_gen.sv | 120 ++++++++++++
 tb/tb_sprite_pixel_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel generator.
package sprite_pkg;

   localparam int unsigned NUM_SPR_DEF = 4;
   localparam int unsigned SPR_DIM_DEF = 16;
   localparam int unsigned DW_DEF      = $clog2(SPR_DIM_DEF);
   localparam int unsigned RGB_W       = 30;
   localparam int unsigned COORD_W     = 10;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               en;
      logic [RGB_W-1:0]   rgb;
   } sprite_t;

   // Fixed shape: a full square with each 2x2 corner block transparent.
   function automatic logic sprOpaque(int unsigned dx, int unsigned dy, int unsigned dim);
      logic cornerX;
      logic cornerY;
      cornerX = (dx < 2) || (dx >= dim - 2);
      cornerY = (dy < 2) || (dy >= dim - 2);
      return !(cornerX && cornerY);
   endfunction

   function automatic logic [SPR_DIM_DEF-1:0][SPR_DIM_DEF-1:0] genMask();
      logic [SPR_DIM_DEF-1:0][SPR_DIM_DEF-1:0] m;
      m = '0;
      for (int unsigned dy = 0; dy < SPR_DIM_DEF; dy++)
         for (int unsigned dx = 0; dx < SPR_DIM_DEF; dx++)
            m[DW_DEF'(dy)][DW_DEF'(dx)] = sprOpaque(dx, dy, SPR_DIM_DEF);
      return m;
   endfunction

   // Indexed [dy][dx]; 1 = opaque.
   localparam logic [SPR_DIM_DEF-1:0][SPR_DIM_DEF-1:0] SPR_MASK = genMask();

endpackage

// File: rtl/sprite_hit.sv
// Stage-1 bounding-box test for one sprite: registers hit and the in-sprite offset.
module sprite_hit
   import sprite_pkg::*;
#(
   parameter  int unsigned SPR_DIM = SPR_DIM_DEF,
   localparam int unsigned DW      = $clog2(SPR_DIM)
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [COORD_W-1:0] iX,
   input  logic [COORD_W-1:0] iY,
   input  logic               iEn,
   input  logic [COORD_W-1:0] iPixel_x,
   input  logic [COORD_W-1:0] iPixel_y,
   output logic               oHit,
   output logic [DW-1:0]      oDx,
   output logic [DW-1:0]      oDy
);

   logic [COORD_W:0] dx;
   logic [COORD_W:0] dy;
   logic             inX;
   logic             inY;

   // Offsets are only meaningful when the sprite origin is not past the pixel,
   // so sprites near the right/bottom edge clip instead of wrapping.
   always_comb begin
      dx  = {1'b0, iPixel_x} - {1'b0, iX};
      dy  = {1'b0, iPixel_y} - {1'b0, iY};
      inX = (iX <= iPixel_x) && (dx < (COORD_W+1)'(SPR_DIM));
      inY = (iY <= iPixel_y) && (dy < (COORD_W+1)'(SPR_DIM));
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oHit <= 1'b0;
         oDx  <= '0;
         oDy  <= '0;
      end else begin
         oHit <= iEn && inX && inY;
         oDx  <= dx[DW-1:0];
         oDy  <= dy[DW-1:0];
      end
   end

endmodule

// File: rtl/sprite_pixel_gen.sv
// Sprite compositor for the VGA controller: 2-cycle pixel pipeline, per-frame shadow commit.
// Optional sticky collision flag enabled by defining SPR_COLLISION_EN.
module sprite_pixel_gen
   import sprite_pkg::*;
#(
   parameter int unsigned      NUM_SPR = NUM_SPR_DEF,
   parameter int unsigned      SPR_DIM = SPR_DIM_DEF,
   parameter logic [RGB_W-1:0] BG_RGB  = 30'h0
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iRequest,
   input  logic [COORD_W-1:0] iPixel_x,
   input  logic [COORD_W-1:0] iPixel_y,
   input  logic               iFrame_start,
   input  logic               iSpr_wr_valid,
   output logic               oSpr_wr_ready,
   input  logic [2:0]         iSpr_idx,
   input  logic [COORD_W-1:0] iSpr_x,
   input  logic [COORD_W-1:0] iSpr_y,
   input  logic               iSpr_en,
   input  logic [RGB_W-1:0]   iSpr_rgb,
   output logic [9:0]         oRed,
   output logic [9:0]         oGreen,
   output logic [9:0]         oBlue,
   output logic               oCollision
);

   localparam int unsigned DW = $clog2(SPR_DIM);

   function automatic logic [SPR_DIM-1:0][SPR_DIM-1:0] buildMask();
      logic [SPR_DIM-1:0][SPR_DIM-1:0] m;
      m = '0;
      for (int unsigned dy = 0; dy < SPR_DIM; dy++)
         for (int unsigned dx = 0; dx < SPR_DIM; dx++)
            m[DW'(dy)][DW'(dx)] = sprOpaque(dx, dy, SPR_DIM);
      return m;
   endfunction

   localparam logic [SPR_DIM-1:0][SPR_DIM-1:0] MASK = buildMask();

   sprite_t                     shadowR [NUM_SPR];
   sprite_t                     activeR [NUM_SPR];
   logic [NUM_SPR-1:0]          hit1;
   logic [DW-1:0]               dx1 [NUM_SPR];
   logic [DW-1:0]               dy1 [NUM_SPR];
   logic                        req1;
   logic [NUM_SPR-1:0]          opaque2;
   logic [NUM_SPR:0][RGB_W-1:0] chainRgb;
   logic                        wrFire;

   assign oSpr_wr_ready = !iFrame_start;
   assign wrFire        = iSpr_wr_valid && oSpr_wr_ready;
   assign chainRgb[NUM_SPR] = BG_RGB;

   for (genvar g = 0; g < NUM_SPR; g++) begin : gSpr
      // A write held across iFrame_start is stalled by ready, so it lands one
      // cycle later and only becomes visible at the following commit.
      always_ff @(posedge iCLK) begin
         if (iRST) begin
            shadowR[g] <= '0;
            activeR[g] <= '0;
         end else begin
            if (wrFire && (iSpr_idx == 3'(g)))
               shadowR[g] <= '{x: iSpr_x, y: iSpr_y, en: iSpr_en, rgb: iSpr_rgb};
            if (iFrame_start)
               activeR[g] <= shadowR[g];
         end
      end

      sprite_hit #(.SPR_DIM(SPR_DIM)) uHit (
         .iCLK     (iCLK),
         .iRST     (iRST),
         .iX       (activeR[g].x),
         .iY       (activeR[g].y),
         .iEn      (activeR[g].en),
         .iPixel_x (iPixel_x),
         .iPixel_y (iPixel_y),
         .oHit     (hit1[g]),
         .oDx      (dx1[g]),
         .oDy      (dy1[g])
      );

      assign opaque2[g]  = hit1[g] && MASK[dy1[g]][dx1[g]];
      // Chain runs from the highest index down so sprite 0 has final say.
      assign chainRgb[g] = opaque2[g] ? activeR[g].rgb : chainRgb[g+1];
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         req1   <= 1'b0;
         oRed   <= '0;
         oGreen <= '0;
         oBlue  <= '0;
      end else begin
         req1 <= iRequest;
         if (req1)
            {oRed, oGreen, oBlue} <= chainRgb[0];
         else
            {oRed, oGreen, oBlue} <= '0;
      end
   end

`ifdef SPR_COLLISION_EN
   logic multiOpaque;
   assign multiOpaque = (opaque2 & (opaque2 - NUM_SPR'(1))) != '0;

   always_ff @(posedge iCLK) begin
      if (iRST)
         oCollision <= 1'b0;
      else if (iFrame_start)
         oCollision <= 1'b0;
      else if (req1 && multiOpaque)
         oCollision <= 1'b1;
   end
`else
   assign oCollision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Directed self-checking bench for sprite_pixel_gen (default parameters).
module tb_sprite_pixel_gen;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iRequest;
   logic [9:0]  iPixel_x;
   logic [9:0]  iPixel_y;
   logic        iFrame_start;
   logic        iSpr_wr_valid;
   logic        oSpr_wr_ready;
   logic [2:0]  iSpr_idx;
   logic [9:0]  iSpr_x;
   logic [9:0]  iSpr_y;
   logic        iSpr_en;
   logic [29:0] iSpr_rgb;
   logic [9:0]  oRed;
   logic [9:0]  oGreen;
   logic [9:0]  oBlue;
   logic        oCollision;

   int nTests = 0;
   int nFail  = 0;

`ifdef SPR_COLLISION_EN
   localparam logic COLL = 1'b1;
`else
   localparam logic COLL = 1'b0;
`endif

   localparam logic [29:0] RED   = 30'h3FF00000;
   localparam logic [29:0] GREEN = 30'h000FFC00;
   localparam logic [29:0] BLUE  = 30'h000003FF;
   localparam logic [29:0] WHITE = 30'h3FFFFFFF;
   localparam logic [29:0] GREY  = 30'h2AAAAAAA;

   sprite_pixel_gen dut (
      .iCLK          (iCLK),
      .iRST          (iRST),
      .iRequest      (iRequest),
      .iPixel_x      (iPixel_x),
      .iPixel_y      (iPixel_y),
      .iFrame_start  (iFrame_start),
      .iSpr_wr_valid (iSpr_wr_valid),
      .oSpr_wr_ready (oSpr_wr_ready),
      .iSpr_idx      (iSpr_idx),
      .iSpr_x        (iSpr_x),
      .iSpr_y        (iSpr_y),
      .iSpr_en       (iSpr_en),
      .iSpr_rgb      (iSpr_rgb),
      .oRed          (oRed),
      .oGreen        (oGreen),
      .oBlue         (oBlue),
      .oCollision    (oCollision)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic writeSpr(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                           input logic en, input logic [29:0] rgb);
      @(negedge iCLK);
      iSpr_idx = idx; iSpr_x = x; iSpr_y = y; iSpr_en = en; iSpr_rgb = rgb;
      iSpr_wr_valid = 1'b1;
      @(posedge iCLK);
      #1 iSpr_wr_valid = 1'b0;
   endtask

   task automatic frameStart();
      @(negedge iCLK);
      iFrame_start = 1'b1;
      @(posedge iCLK);
      #1 iFrame_start = 1'b0;
   endtask

   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic req,
                      input logic [29:0] exp, input string tag);
      @(negedge iCLK);
      iPixel_x = x; iPixel_y = y; iRequest = req;
      @(posedge iCLK);
      @(posedge iCLK);
      #1 chk(tag, {2'b0, oRed, oGreen, oBlue}, {2'b0, exp});
   endtask

   initial begin
      iRST = 1'b1; iRequest = 1'b0; iPixel_x = '0; iPixel_y = '0;
      iFrame_start = 1'b0; iSpr_wr_valid = 1'b0; iSpr_idx = '0;
      iSpr_x = '0; iSpr_y = '0; iSpr_en = 1'b0; iSpr_rgb = '0;
      repeat (3) @(posedge iCLK);
      #1;
      chk("reset_rgb", {2'b0, oRed, oGreen, oBlue}, 32'h0);
      chk("reset_coll", {31'b0, oCollision}, 32'h0);
      chk("reset_ready", {31'b0, oSpr_wr_ready}, 32'h1);
      @(negedge iCLK) iRST = 1'b0;

      // Single red sprite; corner offset (0,0) is transparent.
      writeSpr(3'd0, 10'd100, 10'd50, 1'b1, RED);
      frameStart();
      pix(10'd108, 10'd58, 1'b1, RED,   "basic_red");
      pix(10'd100, 10'd50, 1'b1, 30'h0, "corner_transparent");
      pix(10'd116, 10'd58, 1'b1, 30'h0, "right_of_box");
      pix(10'd99,  10'd58, 1'b1, 30'h0, "left_of_box");

      // Priority: lower index wins on overlap.
      writeSpr(3'd0, 10'd200, 10'd100, 1'b1, RED);
      writeSpr(3'd1, 10'd200, 10'd100, 1'b1, GREEN);
      frameStart();
      pix(10'd205, 10'd105, 1'b1, RED, "priority_red");
      writeSpr(3'd0, 10'd200, 10'd100, 1'b0, RED);
      frameStart();
      pix(10'd205, 10'd105, 1'b1, GREEN, "priority_green");

      // Shadow write is invisible until commit.
      writeSpr(3'd2, 10'd300, 10'd200, 1'b1, BLUE);
      pix(10'd305, 10'd205, 1'b1, 30'h0, "shadow_hidden");
      frameStart();
      pix(10'd305, 10'd205, 1'b1, BLUE, "shadow_committed");

      // Write held across frame_start stalls one cycle.
      @(negedge iCLK);
      iFrame_start = 1'b1;
      iSpr_idx = 3'd3; iSpr_x = 10'd400; iSpr_y = 10'd300; iSpr_en = 1'b1; iSpr_rgb = WHITE;
      iSpr_wr_valid = 1'b1;
      #1 chk("stall_ready", {31'b0, oSpr_wr_ready}, 32'h0);
      @(negedge iCLK);
      iFrame_start = 1'b0;
      #1 chk("accept_ready", {31'b0, oSpr_wr_ready}, 32'h1);
      @(posedge iCLK);
      #1 iSpr_wr_valid = 1'b0;
      pix(10'd405, 10'd305, 1'b1, 30'h0, "stalled_not_visible");
      frameStart();
      pix(10'd405, 10'd305, 1'b1, WHITE, "stalled_after_fs");

      // Edge clipping, no wrap, request gating.
      writeSpr(3'd3, 10'd630, 10'd10, 1'b1, GREY);
      writeSpr(3'd1, 10'd0,   10'd20, 1'b1, GREEN);
      frameStart();
      pix(10'd639, 10'd15, 1'b1, GREY,  "clip_x639");
      pix(10'd5,   10'd19, 1'b1, 30'h0, "row_above_no_wrap");
      pix(10'd5,   10'd20, 1'b1, GREEN, "x0_top_row");
      pix(10'd5,   10'd20, 1'b0, 30'h0, "req_low_zero");

      // Overlapping opaque sprites and the collision flag.
      writeSpr(3'd2, 10'd500, 10'd300, 1'b1, BLUE);
      writeSpr(3'd3, 10'd500, 10'd300, 1'b1, GREY);
      frameStart();
      chk("coll_clear_before", {31'b0, oCollision}, 32'h0);
      pix(10'd505, 10'd305, 1'b1, BLUE, "overlap_priority");
      chk("coll_set", {31'b0, oCollision}, {31'b0, COLL});
      pix(10'd10, 10'd400, 1'b1, 30'h0, "bg_after_overlap");
      chk("coll_sticky", {31'b0, oCollision}, {31'b0, COLL});
      frameStart();
      chk("coll_cleared_fs", {31'b0, oCollision}, 32'h0);

      // Mid-frame reset behaves like power-on and drops shadow contents.
      pix(10'd505, 10'd305, 1'b1, BLUE, "pre_reset_rgb");
      @(negedge iCLK) iRST = 1'b1;
      @(posedge iCLK);
      #1;
      chk("midreset_rgb", {2'b0, oRed, oGreen, oBlue}, 32'h0);
      chk("midreset_coll", {31'b0, oCollision}, 32'h0);
      @(negedge iCLK) iRST = 1'b0;
      @(posedge iCLK);
      @(posedge iCLK);
      #1 chk("post_reset_rgb", {2'b0, oRed, oGreen, oBlue}, 32'h0);
      frameStart();
      pix(10'd505, 10'd305, 1'b1, 30'h0, "shadow_lost");

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
